// File: rtl/minisys_md_pkg.sv
// Shared definitions for the minisys multiply/divide unit: state encoding,
// operand width, divider latencies and the md opcode shared with the multiplier.
package minisys_md_pkg;

  localparam int MD_WIDTH     = 32;
  localparam int DIV_LATENCY  = 33;
  localparam int DIVZ_LATENCY = 2;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_ZERO = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  typedef enum logic [1:0] {
    MD_OP_MULT  = 2'd0,
    MD_OP_MULTU = 2'd1,
    MD_OP_DIV   = 2'd2,
    MD_OP_DIVU  = 2'd3
  } md_op_e;

endpackage

// File: rtl/minisys_divider_div_step.sv
// One radix-2 restoring division step: shift {rem, quo} left and try to
// subtract the divisor magnitude from the widened remainder.
module div_step
  import minisys_md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic           fits;

  // The shifted remainder needs one extra bit when the divisor is near 2^WIDTH.
  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, dvs_i});

  always_comb begin
    if (fits) begin
      rem_o = shifted[WIDTH-1:0] - dvs_i;
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/minisys_divider.sv
// Iterative DIV/DIVU unit for the EXE stage: start pulse in, busy while
// iterating, one-cycle divover with hi = remainder and lo = quotient.
module minisys_divider
  import minisys_md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic             signed_op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             divbusy,
  output logic             divover,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] ST_IDLE = MD_IDLE;
  localparam logic [1:0] ST_CALC = MD_CALC;
  localparam logic [1:0] ST_ZERO = MD_ZERO;
  localparam logic [1:0] ST_DONE = MD_DONE;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic             dvd_neg, dvs_neg;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  assign dvd_neg = signed_op & dividend[WIDTH-1];
  assign dvs_neg = signed_op & divisor[WIDTH-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    case (state_q)
      ST_CALC: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_DONE;
            lo_d    = q_neg_q ? -step_quo : step_quo;
            hi_d    = r_neg_q ? -step_rem : step_rem;
          end
        end
      end
      ST_ZERO: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          // quo_q holds |dividend|; re-applying the sign restores the raw operand.
          state_d = ST_DONE;
          hi_d    = r_neg_q ? -quo_q : quo_q;
          lo_d    = '1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (start && !cancel) begin
          rem_d   = '0;
          quo_d   = dvd_neg ? -dividend : dividend;
          dvs_d   = dvs_neg ? -divisor : divisor;
          q_neg_d = dvd_neg ^ dvs_neg;
          r_neg_d = dvd_neg;
          cnt_d   = CNT_W'(WIDTH);
          state_d = (divisor == '0) ? ST_ZERO : ST_CALC;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

  assign divbusy = (state_q == ST_CALC) || (state_q == ST_ZERO);
  assign divover = (state_q == ST_DONE);
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule
